demux_buf: RTL

- Inverse of the datapath 2:1 select: one WIDTH-bit producer stream is steered to one of two consumer streams by a select bit.
- sel=1 routes to port 1; sel=0 routes to port 2. This matches the existing mux convention (sel=1 -> in_1).
- Each destination has a one-entry registered holding slot with valid/ready handshake. A stalled consumer only back-pressures traffic aimed at it.
- Sits between execute/writeback result producers and their consumers (register file write port, memory store path).

---
 rtl/demux_buf.sv | 103 ++++++++++
 1 files changed

// File: rtl/demux_buf.sv
// demux_buf: 1-to-2 stream demultiplexer with a one-entry registered slot per destination.
// Optional per-port drain counters (cnt_1/cnt_2) are enabled with `define DEMUX_BUF_CNT_EN.
module demux_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             flush,
  output logic             out_valid_1,
  input  logic             out_ready_1,
  output logic [WIDTH-1:0] out_data_1,
  output logic             out_valid_2,
  input  logic             out_ready_2,
  output logic [WIDTH-1:0] out_data_2
`ifdef DEMUX_BUF_CNT_EN
  ,
  output logic [15:0]      cnt_1,
  output logic [15:0]      cnt_2
`endif
);

  logic             r_valid_1;
  logic             r_valid_2;
  logic [WIDTH-1:0] r_data_1;
  logic [WIDTH-1:0] r_data_2;

  logic w_drain_1;
  logic w_drain_2;
  logic w_free_1;
  logic w_free_2;
  logic w_accept;
  logic w_load_1;
  logic w_load_2;

  assign w_drain_1 = r_valid_1 & out_ready_1;
  assign w_drain_2 = r_valid_2 & out_ready_2;
  assign w_free_1  = ~r_valid_1 | w_drain_1;
  assign w_free_2  = ~r_valid_2 | w_drain_2;

  // Only the selected port's slot state gates acceptance, so a stalled
  // consumer never blocks traffic headed to the other port.
  assign in_ready = ~flush & (in_sel ? w_free_1 : w_free_2);
  assign w_accept = in_valid & in_ready;
  assign w_load_1 = w_accept & in_sel;
  assign w_load_2 = w_accept & ~in_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid_1 <= 1'b0;
      r_data_1  <= '0;
    end else if (flush) begin
      r_valid_1 <= 1'b0;
    end else if (w_load_1) begin
      r_valid_1 <= 1'b1;
      r_data_1  <= in_data;
    end else if (w_drain_1) begin
      r_valid_1 <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid_2 <= 1'b0;
      r_data_2  <= '0;
    end else if (flush) begin
      r_valid_2 <= 1'b0;
    end else if (w_load_2) begin
      r_valid_2 <= 1'b1;
      r_data_2  <= in_data;
    end else if (w_drain_2) begin
      r_valid_2 <= 1'b0;
    end
  end

  assign out_valid_1 = r_valid_1;
  assign out_data_1  = r_data_1;
  assign out_valid_2 = r_valid_2;
  assign out_data_2  = r_data_2;

`ifdef DEMUX_BUF_CNT_EN
  logic [15:0] r_cnt_1;
  logic [15:0] r_cnt_2;

  // Counters track completed transfers, including a drain in a flush cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_1 <= '0;
      r_cnt_2 <= '0;
    end else begin
      if (w_drain_1) r_cnt_1 <= r_cnt_1 + 16'd1;
      if (w_drain_2) r_cnt_2 <= r_cnt_2 + 16'd1;
    end
  end

  assign cnt_1 = r_cnt_1;
  assign cnt_2 = r_cnt_2;
`endif

endmodule
